// File: rtl/cascade_controller.sv
// cascade_controller
// Runs one detection window through a Haar cascade. For every stage it
// fetches the stage's weak-classifier count, issues one request per feature
// to the evaluator, sums the returned votes and compares the sum with the
// stage threshold. A stage below threshold rejects the window; passing the
// last stage reports a face.
//
// Ports
//   clk_i           clock, all state on the rising edge
//   rst_i           asynchronous active-high reset
//   start_i         begin a window (only looked at while idle)
//   stage_num_o     current stage, addresses the count and threshold ROMs
//   feat_amount_i   feature count of the current stage (combinational)
//   stage_thresh_i  signed threshold of the current stage (combinational)
//   feat_idx_o      flat index of the requested feature
//   feat_req_o      feature-evaluation request
//   feat_valid_i    evaluator result valid, completes the request
//   feat_vote_i     signed weak-classifier vote
//   busy_o          window in progress
//   done_o          one-cycle completion pulse
//   face_o          result, held until the next accepted start
module cascade_controller #(
  parameter  int NUM_STAGES = 22,
  parameter  int VOTE_W     = 16,
  parameter  int ACC_W      = 24,
  parameter  int IDX_W      = 12,
  parameter  int FCNT_W     = 8,
  localparam int SN_W       = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  output logic [SN_W-1:0]          stage_num_o,
  input  logic [FCNT_W-1:0]        feat_amount_i,
  input  logic signed [VOTE_W-1:0] stage_thresh_i,
  output logic [IDX_W-1:0]         feat_idx_o,
  output logic                     feat_req_o,
  input  logic                     feat_valid_i,
  input  logic signed [VOTE_W-1:0] feat_vote_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     face_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_REQ,
    S_CHECK,
    S_DONE
  } state_t;

  state_t                    state_q, state_d;
  logic [SN_W-1:0]           stage_q, stage_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [FCNT_W-1:0]         cnt_q, cnt_d;
  logic [FCNT_W-1:0]         total_q, total_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic                      face_q, face_d;

  logic signed [ACC_W-1:0]   vote_ext;
  logic signed [ACC_W-1:0]   thresh_ext;

  assign vote_ext   = {{(ACC_W-VOTE_W){feat_vote_i[VOTE_W-1]}}, feat_vote_i};
  assign thresh_ext = {{(ACC_W-VOTE_W){stage_thresh_i[VOTE_W-1]}}, stage_thresh_i};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      stage_q <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      total_q <= '0;
      acc_q   <= '0;
      face_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      total_q <= total_d;
      acc_q   <= acc_d;
      face_q  <= face_d;
    end
  end

  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    total_d = total_q;
    acc_d   = acc_q;
    face_d  = face_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          stage_d = '0;
          idx_d   = '0;
          cnt_d   = '0;
          acc_d   = '0;
          face_d  = 1'b0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        total_d = feat_amount_i;
        cnt_d   = '0;
        acc_d   = '0;
        // An empty stage goes straight to the threshold test with acc = 0.
        state_d = (feat_amount_i == '0) ? S_CHECK : S_REQ;
      end
      S_REQ: begin
        if (feat_valid_i) begin
          acc_d = acc_q + vote_ext;
          // The flat index advances on every transfer, including the last
          // one of a stage, so it points at the next stage's first feature.
          idx_d = idx_q + IDX_W'(1);
          if (cnt_q == total_q - FCNT_W'(1)) state_d = S_CHECK;
          else                               cnt_d   = cnt_q + FCNT_W'(1);
        end
      end
      S_CHECK: begin
        if (acc_q < thresh_ext) begin
          face_d  = 1'b0;
          state_d = S_DONE;
        end else if (stage_q == SN_W'(NUM_STAGES-1)) begin
          face_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          stage_d = stage_q + SN_W'(1);
          state_d = S_LOAD;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs come straight from registered state.
  assign stage_num_o = stage_q;
  assign feat_idx_o  = idx_q;
  assign feat_req_o  = (state_q == S_REQ);
  assign busy_o      = (state_q == S_LOAD) || (state_q == S_REQ) || (state_q == S_CHECK);
  assign done_o      = (state_q == S_DONE);
  assign face_o      = face_q;

endmodule

// File: tb/tb_cascade_controller.sv
// Directed bench for cascade_controller using the 22-stage frontal-face
// stage sizes (2135 features). Count/threshold/vote ROMs are modelled as
// lookups on the controller's own addresses.
module tb_cascade_controller;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               start = 1'b0;
  logic [4:0]         stage_num;
  logic [7:0]         feat_amount;
  logic signed [15:0] stage_thresh;
  logic [11:0]        feat_idx;
  logic               feat_req;
  logic               feat_valid = 1'b0;
  logic signed [15:0] feat_vote;
  logic               busy, done, face;

  int                 cnt_tbl [32];
  logic signed [15:0] thr_mem [32];
  logic signed [15:0] vote_mem [4096];

  assign feat_amount  = 8'(cnt_tbl[stage_num]);
  assign stage_thresh = thr_mem[stage_num];
  assign feat_vote    = vote_mem[feat_idx];

  cascade_controller dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .start_i        (start),
    .stage_num_o    (stage_num),
    .feat_amount_i  (feat_amount),
    .stage_thresh_i (stage_thresh),
    .feat_idx_o     (feat_idx),
    .feat_req_o     (feat_req),
    .feat_valid_i   (feat_valid),
    .feat_vote_i    (feat_vote),
    .busy_o         (busy),
    .done_o         (done),
    .face_o         (face)
  );

  always #5 clk = ~clk;

  int ec = 0;
  always @(posedge clk) ec <= ec + 1;

  bit stall = 1'b0;
  always @(posedge clk) begin
    #1;
    feat_valid = stall ? ($urandom_range(2) == 0) : 1'b1;
  end

  int n_chk = 0, n_fail = 0;
  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Handshake monitor, sampled on the falling edge.
  int          done_cnt = 0, stab_err = 0, holds = 0;
  int          idx_log[$];
  bit          prev_hold = 1'b0;
  logic [11:0] prev_idx = '0;
  always @(negedge clk) begin
    if (rst) begin
      prev_hold = 1'b0;
    end else begin
      if (done) done_cnt++;
      if (prev_hold && (!feat_req || feat_idx != prev_idx)) stab_err++;
      if (feat_req && feat_valid) idx_log.push_back(int'(feat_idx));
      if (feat_req && !feat_valid) holds++;
      prev_hold = feat_req && !feat_valid;
      prev_idx  = feat_idx;
    end
  end

  task automatic set_votes(input int v);
    for (int i = 0; i < 4096; i++) vote_mem[i] = 16'(v);
  endtask

  task automatic set_thr(input int v);
    for (int i = 0; i < 32; i++) thr_mem[i] = 16'(v);
  endtask

  // Start one window and check its outcome. exp_lat < 0 skips the latency
  // check; noise pulses start while the window is busy.
  task automatic run(input string tag, input int exp_lat, input int exp_stage,
                     input int exp_face, input int exp_idx, input bit noise);
    int T, lat, d0;
    bit seen;
    idx_log.delete();
    d0 = done_cnt; seen = 1'b0; lat = -1;
    @(posedge clk); #1 start = 1'b1; T = ec + 1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    chk({tag, " busy@T+1"},  int'(busy), 1);
    chk({tag, " face clr"},  int'(face), 0);
    chk({tag, " stage clr"}, int'(stage_num), 0);
    @(negedge clk);
    chk({tag, " req@T+2"},   int'(feat_req), 1);
    chk({tag, " idx@T+2"},   int'(feat_idx), 0);
    for (int k = 0; k < 6000 && !seen; k++) begin
      if (done) begin
        seen = 1'b1;
        lat  = ec + 1 - T;
      end else begin
        @(posedge clk); #1;
        start = noise && (k % 4 == 1);
        @(negedge clk);
      end
    end
    start = 1'b0;
    chk({tag, " done seen"}, int'(seen), 1);
    if (exp_lat >= 0) chk({tag, " latency"}, lat, exp_lat);
    chk({tag, " face"},      int'(face), exp_face);
    chk({tag, " stage"},     int'(stage_num), exp_stage);
    chk({tag, " feat_idx"},  int'(feat_idx), exp_idx);
    chk({tag, " busy@done"}, int'(busy), 0);
    chk({tag, " req@done"},  int'(feat_req), 0);
    repeat (6) @(negedge clk);
    chk({tag, " done count"}, done_cnt - d0, 1);
    chk({tag, " face held"},  int'(face), exp_face);
  endtask

  initial begin
    int s5, s6, r;
    bit hit;
    cnt_tbl = '{3, 16, 21, 39, 33, 44, 50, 51, 56, 71, 80, 103, 111, 102, 135,
                137, 140, 160, 177, 182, 211, 213, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    set_votes(-1);
    set_thr(0);

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst stage", int'(stage_num), 0);
    chk("rst idx",   int'(feat_idx), 0);
    chk("rst req",   int'(feat_req), 0);
    chk("rst busy",  int'(busy), 0);
    chk("rst done",  int'(done), 0);
    chk("rst face",  int'(face), 0);
    rst = 1'b0;

    // Early reject in stage 0: sum -3 < 0
    run("reject", 6, 0, 0, 3, 1'b0);
    chk("reject nreq", idx_log.size(), 3);
    if (idx_log.size() == 3) begin
      chk("reject req0", idx_log[0], 0);
      chk("reject req1", idx_log[1], 1);
      chk("reject req2", idx_log[2], 2);
    end

    // Full pass: 22*2 + 2135 + 1 cycles
    set_votes(1);
    run("full", 2180, 21, 1, 2135, 1'b0);

    // Stage 0 sums to exactly its threshold and passes; stage 1 rejects
    vote_mem[0] = 16'sd5; vote_mem[1] = -16'sd2; vote_mem[2] = -16'sd3;
    thr_mem[0] = 16'sd0; thr_mem[1] = 16'sd32767;
    run("equal", 24, 1, 0, 19, 1'b0);
    thr_mem[0] = 16'sd1;
    run("above", 6, 0, 0, 3, 1'b0);

    // start pulses while busy change nothing
    thr_mem[0] = 16'sd0;
    run("noise", 24, 1, 0, 19, 1'b1);

    // Stalled handshake with random votes; stage 5 passes at equality and
    // stage 6 misses by one, so the outcome depends on the exact sums.
    for (int i = 0; i < 4096; i++) begin
      r = int'($urandom_range(6));
      vote_mem[i] = 16'(r - 3);
    end
    s5 = 0; s6 = 0;
    for (int i = 112; i < 156; i++) s5 += int'(vote_mem[i]);
    for (int i = 156; i < 206; i++) s6 += int'(vote_mem[i]);
    set_thr(-32768);
    thr_mem[5] = 16'(s5);
    thr_mem[6] = 16'(s6 + 1);
    stab_err = 0; holds = 0;
    stall = 1'b1;
    run("stall", -1, 6, 0, 206, 1'b0);
    stall = 1'b0;
    chk("stall idx stable", stab_err, 0);
    chk("stall had holds",  int'(holds > 0), 1);

    // Asynchronous reset in the middle of stage 3
    set_votes(1);
    set_thr(0);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    hit = 1'b0;
    for (int k = 0; k < 500 && !hit; k++) begin
      @(negedge clk);
      hit = (stage_num == 5'd3);
    end
    chk("rst reach st3", int'(hit), 1);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst stage", int'(stage_num), 0);
    chk("arst idx",   int'(feat_idx), 0);
    chk("arst req",   int'(feat_req), 0);
    chk("arst busy",  int'(busy), 0);
    chk("arst done",  int'(done), 0);
    chk("arst face",  int'(face), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    r = done_cnt;
    repeat (5) @(negedge clk);
    chk("arst no done", done_cnt - r, 0);
    chk("arst idle",    int'(busy), 0);
    chk("arst no req",  int'(feat_req), 0);
    set_votes(-1);
    run("restart", 6, 0, 0, 3, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cascade_controller.md
# cascade_controller

Sequencer that runs one detection window through the 22-stage Haar cascade. It drives `stage_num` into the per-stage feature-count lookup and consumes `feat_amount`. It issues one request per weak classifier to the feature evaluator and accumulates the returned votes. At the end of each stage it compares the sum against the stage threshold and either rejects the window early or advances; after the last stage it reports a face.

## Interface
- NUM_STAGES, 22, number of cascade stages
- VOTE_W, 16, signed weak-classifier vote and stage-threshold width
- ACC_W, 24, signed stage-accumulator width (213 × 2^15 fits; no overflow possible)
- IDX_W, 12, global feature index width (2135 features total)

- Clk  in  1  single clock, all state rising-edge
- Reset  in  1  asynchronous, active-high
- start  in  1  begin evaluating a window; sampled only in IDLE
- stage_num  out  int  current stage, to the feature-count lookup and threshold ROM
- feat_amount  in  int  features in current stage, combinational from `stage_num`
- stage_thresh  in  VOTE_W signed  threshold of current stage, combinational from `stage_num`
- feat_idx  out  IDX_W  global feature index (cumulative across stages) of requested feature
- feat_req  out  1  feature-evaluation request
- feat_valid  in  1  evaluator result valid
- feat_vote  in  VOTE_W signed  weak-classifier vote, valid with `feat_valid`
- busy  out  1  high from the cycle after accepted `start` until `done`
- done  out  1  one-cycle completion pulse
- face  out  1  result; valid at `done`, held until next accepted `start`

## Operation
- States: IDLE, LOAD, REQ, CHECK, DONE.
- IDLE:
  - On `start` = 1: clear acc, `stage_num`, `feat_idx`, `feat_cnt` and `face`, then go to LOAD.
  - `start` in any other state is ignored.
- LOAD:
  - Latch `feat_amount` into `feat_total`, clear `feat_cnt` and acc.
  - If `feat_amount` = 0, go to CHECK; else go to REQ.
- REQ: `feat_req` = 1. When `feat_valid` = 1:
  - acc += sign-extended `feat_vote`.
  - If `feat_cnt` = `feat_total`−1, go to CHECK. `feat_idx` still increments.
  - Else increment `feat_cnt` and `feat_idx`, and stay in REQ.
- `feat_valid` while `feat_req` = 0 is ignored.
- CHECK:
  - acc < `stage_thresh` (signed): reject. Set `face` = 0, go to DONE.
  - acc ≥ `stage_thresh` and `stage_num` = NUM_STAGES−1: set `face` = 1, go to DONE.
  - Otherwise increment `stage_num` and go to LOAD.
- DONE: `done` = 1 for this cycle only, then go to IDLE.
- `feat_idx` is never reset between stages. It addresses a flat feature ROM and its final value equals the number of features consumed.

## Timing
- Reset values: state IDLE, `stage_num` 0, `feat_idx` 0, `feat_req` 0, `busy` 0, `done` 0, `face` 0, acc 0.
- All outputs are registered or decoded from registered state only.
- `start` is sampled at edge T. LOAD occupies cycle T+1. `feat_req` is first high in cycle T+2.
- Handshake:
  - `feat_req` and `feat_idx` are held stable until the edge where `feat_valid` = 1.
  - Back-to-back transfers are allowed, at 1 feature/cycle with `feat_valid` tied high.
  - `feat_req` drops in the cycle after the last feature of a stage.
- Per stage: 1 (LOAD) + N transfers + 1 (CHECK) cycles at minimum.
- `done` is high one cycle after CHECK. `busy` falls in the same cycle `done` rises.
- Asynchronous `Reset` mid-window: all registers return to reset values immediately.
  - No `done` pulse.
  - An in-flight `feat_valid` after reset is ignored.
- `stage_thresh` is sampled only in CHECK. `feat_amount` is sampled only in LOAD.

## Test plan
- Early reject:
  - Stimulus: `feat_valid` tied 1, all votes −1, `stage_thresh` 0, `start` at T.
  - Response: `feat_idx` 0,1,2 requested. `done` at T+6 with `face` = 0 and `stage_num` = 0.
- Full pass:
  - Stimulus: votes +1, thresholds 0, `feat_valid` tied 1.
  - Response: `done` at T+2180 with `face` = 1. Final `feat_idx` = 2135, `stage_num` = 21.
- Threshold equality:
  - Stimulus: stage 0 votes +5,−2,−3, `stage_thresh` 0.
  - Response: stage passes and `stage_num` becomes 1. With `stage_thresh` 1, the window is rejected.
- Stalled handshake:
  - Stimulus: `feat_valid` asserted every 3rd cycle, random.
  - Response: `feat_idx` stable while `feat_req` = 1 and `feat_valid` = 0. Acc sum matches the model.
- Reset mid-stage 3:
  - Stimulus: assert `Reset` asynchronously.
  - Response: all outputs are at reset values before the next edge. A subsequent `start` restarts from stage 0, `feat_idx` 0.
- `start` pulses while `busy`: ignored. Exactly one `done` per accepted `start`, and the result is unchanged.
